// File: rtl/ysyx_bus_rr_arbiter.sv
// ysyx_bus_rr_arbiter: round-robin arbiter from NREQ simple requesters onto one 64-bit AXI4
// master port. One transaction in flight; sub-word requests are lane-aligned on the way out
// and the load data is shifted back down to the LSBs.
// Optional watchdog: define YSYX_BUS_TIMEOUT_EN to abort a stalled transaction with an error.
module ysyx_bus_rr_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TMO_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ*4-1:0]        req_strb,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [ADDR_W-1:0]        io_master_araddr,
  output logic [2:0]               io_master_arsize,
  output logic                     io_master_arvalid,
  output logic [7:0]               io_master_arlen,
  output logic [1:0]               io_master_arburst,
  output logic [3:0]               io_master_arid,
  input  logic                     io_master_arready,
  input  logic [63:0]              io_master_rdata,
  input  logic [1:0]               io_master_rresp,
  input  logic                     io_master_rvalid,
  input  logic                     io_master_rlast,
  output logic                     io_master_rready,
  output logic [ADDR_W-1:0]        io_master_awaddr,
  output logic [2:0]               io_master_awsize,
  output logic                     io_master_awvalid,
  output logic [7:0]               io_master_awlen,
  output logic [1:0]               io_master_awburst,
  output logic [3:0]               io_master_awid,
  input  logic                     io_master_awready,
  output logic [63:0]              io_master_wdata,
  output logic [7:0]               io_master_wstrb,
  output logic                     io_master_wvalid,
  output logic                     io_master_wlast,
  input  logic                     io_master_wready,
  input  logic [1:0]               io_master_bresp,
  input  logic                     io_master_bvalid,
  output logic                     io_master_bready
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_q, rr_d, idx_q, idx_d, grant_idx, scan_idx;
  logic                grant_found;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          strb_q, strb_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [31:0]         rd_lane, wd_shift;
  logic [3:0]          strb_shift;
  logic [2:0]          size;
  logic                aw_hs, w_hs;

`ifdef YSYX_BUS_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_q, tmo_d;
`else
  logic                unused_tmo;
  assign unused_tmo = (TMO_W == 0);
`endif
  logic                unused_rlast;
  assign unused_rlast = io_master_rlast;

  // Lane steering: loads pick the addressed 32-bit half, stores shift into position
  assign rd_lane    = addr_q[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
  assign wd_shift   = wdata_q[31:0] << {addr_q[1:0], 3'b000};
  assign strb_shift = strb_q << addr_q[1:0];

  // AXI size from the byte mask; anything not 1/3 is treated as a full word
  always_comb begin
    size = 3'b010;
    unique case (strb_q)
      4'h1:    size = 3'b000;
      4'h3:    size = 3'b001;
      default: size = 3'b010;
    endcase
  end

  // Round-robin scan starting at rr_q, first pending requester wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = IdxW'((32'(rr_q) + k) % NREQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign aw_hs = io_master_awvalid && io_master_awready;
  assign w_hs  = io_master_wvalid && io_master_wready;

  // Next-state, latched request and registered response
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    req_ready   = '0;
`ifdef YSYX_BUS_TIMEOUT_EN
    tmo_d       = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          idx_d     = grant_idx;
          write_d   = req_write[grant_idx];
          addr_d    = req_addr[grant_idx*ADDR_W +: ADDR_W];
          wdata_d   = req_wdata[grant_idx*DATA_W +: DATA_W];
          strb_d    = req_strb[grant_idx*4 +: 4];
          rr_d      = IdxW'((32'(grant_idx) + 32'd1) % NREQ);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write[grant_idx] ? StAwW : StAr;
        end
      end
      StAr: begin
        if (io_master_arready) state_d = StR;
      end
      StR: begin
        if (io_master_rvalid) begin
          rsp_valid_d[idx_q] = 1'b1;
          rsp_rdata_d        = DATA_W'(rd_lane >> {addr_q[1:0], 3'b000});
          rsp_err_d          = (io_master_rresp != 2'b00);
          state_d            = StIdle;
        end
      end
      StAwW: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StB;
      end
      StB: begin
        if (io_master_bvalid) begin
          rsp_valid_d[idx_q] = 1'b1;
          rsp_err_d          = (io_master_bresp != 2'b00);
          state_d            = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef YSYX_BUS_TIMEOUT_EN
    // Watchdog expiry overrides whatever the channel did this cycle
    if (state_q != StIdle && tmo_q == '1) begin
      state_d            = StIdle;
      rsp_valid_d        = '0;
      rsp_valid_d[idx_q] = 1'b1;
      rsp_rdata_d        = '0;
      rsp_err_d          = 1'b1;
    end
    if (state_d == state_q && state_q != StIdle) tmo_d = tmo_q + 1'b1;
`endif
  end

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef YSYX_BUS_TIMEOUT_EN
  // Watchdog counter, cleared on every state change
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign io_master_araddr  = addr_q;
  assign io_master_arsize  = size;
  assign io_master_arvalid = (state_q == StAr);
  assign io_master_arlen   = 8'd0;
  assign io_master_arburst = 2'b01;
  assign io_master_arid    = 4'd0;
  assign io_master_rready  = (state_q == StR);

  assign io_master_awaddr  = addr_q;
  assign io_master_awsize  = size;
  assign io_master_awvalid = (state_q == StAwW) && !aw_done_q;
  assign io_master_awlen   = 8'd0;
  assign io_master_awburst = 2'b01;
  assign io_master_awid    = 4'd0;
  assign io_master_wdata   = {wd_shift, wd_shift};
  assign io_master_wstrb   = addr_q[2] ? {strb_shift, 4'h0} : {4'h0, strb_shift};
  assign io_master_wvalid  = (state_q == StAwW) && !w_done_q;
  assign io_master_wlast   = 1'b1;
  assign io_master_bready  = (state_q == StB);

endmodule
